// File: rtl/id_operand_stage_pkg.sv
// Shared encodings for the ID operand stage: branch types, interlock FSM states, reset level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_operand_stage_pkg;

    // Branch type field as produced by the decoder.
    typedef enum logic [1:0] {
        BrNone = 2'b00,
        BrB    = 2'b01,
        BrBeqz = 2'b10,
        BrBnez = 2'b11
    } br_type_e;

    // StInterlock: bubbles are issued while a load-use hazard persists.
    // StSquash:    the instruction after a taken branch is turned into a bubble.
    typedef enum logic [1:0] {
        StRun       = 2'b00,
        StInterlock = 2'b01,
        StSquash    = 2'b10
    } fsm_state_e;

    // Reset is active-low.
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Priority forwarding match for one source operand over NUM_FWD result channels.
// Latency: combinational.
// Backpressure: none; reports load_hit_o so the caller can interlock.
//
// Ports:
//   addr_i / re_i / rf_data_i     source address, read enable, register-file data
//   fwd_we_i / fwd_load_i         per-channel write enable and "result not ready" flag
//   fwd_waddr_i / fwd_wdata_i     packed per-channel destination and data, channel 0 in the LSBs
//   data_o                        resolved operand
//   hit_o                         some channel supplies this operand
//   load_hit_o                    the winning channel is a pending load
module id_operand_stage_fwd_mux #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_FWD  = 2,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic                      re_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD-1:0]        fwd_load_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      hit_o,
    output logic                      load_hit_o
);

    logic              zero_src;
    logic              match_vld;
    logic              match_load;
    logic [DATA_W-1:0] match_dat;

    // Hardwired zero register: never forwarded, never interlocked.
    assign zero_src = (ZERO_REG != 0) && (addr_i == '0);

    // Walk from oldest to youngest so the lowest matching index is the
    // last one written and therefore wins. A younger non-load result
    // thereby shadows an older pending load to the same register.
    always_comb begin
        match_vld  = 1'b0;
        match_load = 1'b0;
        match_dat  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && (fwd_waddr_i[i*ADDR_W +: ADDR_W] == addr_i)) begin
                match_vld  = 1'b1;
                match_load = fwd_load_i[i];
                match_dat  = fwd_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign hit_o      = re_i & ~zero_src & match_vld;
    assign load_hit_o = hit_o & match_load;

    always_comb begin
        if (!re_i || zero_src) begin
            data_o = '0;
        end else if (hit_o) begin
            data_o = match_dat;
        end else begin
            data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand resolution, load-use interlock, branch resolution and the ID/EX register.
// Latency: operands/branch combinational; ex_* outputs one cycle after the ID inputs.
// Backpressure: stall_req_o holds ID on a load-use hazard; stall_i freezes ID/EX; flush_i clears it.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   valid_i, pc_i                 ID instruction present, its PC
//   reg{0,1}_addr/re/data_i       source fields and register-file read data
//   imm_i, br_type_i              branch offset and type (none, B, BEQZ, BNEZ on reg0)
//   we_i, waddr_i                 destination write enable and address
//   fwd_*_i                       NUM_FWD packed forwarding channels, index 0 youngest
//   stall_i, flush_i              downstream hold / clear of the ID/EX register
//   stall_req_o                   ID cannot advance (load-use hazard)
//   branch_flag_o, branch_addr_o  taken-branch redirect and target
//   ex_*_o                        registered ID/EX contents
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int NUM_FWD    = 2,
    parameter int ZERO_REG   = 0,
    parameter int DELAY_SLOT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [DATA_W-1:0]         pc_i,
    input  logic [ADDR_W-1:0]         reg0_addr_i,
    input  logic [ADDR_W-1:0]         reg1_addr_i,
    input  logic                      reg0_re_i,
    input  logic                      reg1_re_i,
    input  logic [DATA_W-1:0]         reg0_data_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [1:0]                br_type_i,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD-1:0]        fwd_load_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stall_req_o,
    output logic                      branch_flag_o,
    output logic [DATA_W-1:0]         branch_addr_o,
    output logic                      ex_valid_o,
    output logic [DATA_W-1:0]         ex_reg0_data_o,
    output logic [DATA_W-1:0]         ex_reg1_data_o,
    output logic                      ex_we_o,
    output logic [ADDR_W-1:0]         ex_waddr_o
);

    typedef struct packed {
        logic              vld;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] op0;
        logic [DATA_W-1:0] op1;
    } idex_t;

    idex_t      ex_q, ex_d, capture;
    fsm_state_e state_q, state_d;
    br_type_e   br_type;

    logic [DATA_W-1:0] op0_dat, op1_dat;
    logic              op0_hit, op1_hit;
    logic              op0_load, op1_load;
    logic              br_cond;
    logic              squash_next;

    id_operand_stage_fwd_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_FWD  (NUM_FWD),
        .ZERO_REG (ZERO_REG)
    ) u_fwd0 (
        .addr_i      (reg0_addr_i),
        .re_i        (reg0_re_i),
        .rf_data_i   (reg0_data_i),
        .fwd_we_i    (fwd_we_i),
        .fwd_load_i  (fwd_load_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .data_o      (op0_dat),
        .hit_o       (op0_hit),
        .load_hit_o  (op0_load)
    );

    id_operand_stage_fwd_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_FWD  (NUM_FWD),
        .ZERO_REG (ZERO_REG)
    ) u_fwd1 (
        .addr_i      (reg1_addr_i),
        .re_i        (reg1_re_i),
        .rf_data_i   (reg1_data_i),
        .fwd_we_i    (fwd_we_i),
        .fwd_load_i  (fwd_load_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .data_o      (op1_dat),
        .hit_o       (op1_hit),
        .load_hit_o  (op1_load)
    );

    // ------------------------------------------------------------------
    // Hazard and branch resolution
    // ------------------------------------------------------------------
    assign stall_req_o = valid_i & (op0_load | op1_load);

    assign br_type = br_type_e'(br_type_i);

    // The condition uses the forwarded reg0 value.
    always_comb begin
        case (br_type)
            BrB:     br_cond = 1'b1;
            BrBeqz:  br_cond = (op0_dat == '0);
            BrBnez:  br_cond = (op0_dat != '0);
            default: br_cond = 1'b0;
        endcase
    end

    // A branch sitting in the squashed slot is itself discarded, and a
    // stalled branch must not redirect until its operand is real.
    assign branch_flag_o = valid_i & ~stall_req_o & (state_q != StSquash) & br_cond;
    assign branch_addr_o = pc_i + {{(DATA_W-1){1'b0}}, 1'b1} + imm_i;

    assign squash_next = branch_flag_o && (DELAY_SLOT == 0);

    // ------------------------------------------------------------------
    // ID/EX register and interlock FSM
    // ------------------------------------------------------------------
    always_comb begin
        capture.vld   = valid_i;
        capture.we    = we_i & valid_i;
        capture.waddr = waddr_i;
        capture.op0   = op0_dat;
        capture.op1   = op1_dat;
    end

    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        if (flush_i) begin
            ex_d    = '0;
            state_d = StRun;
        end else if (!stall_i) begin
            case (state_q)
                StRun, StInterlock: begin
                    if (stall_req_o) begin
                        ex_d    = '0;
                        state_d = StInterlock;
                    end else begin
                        ex_d    = capture;
                        // A branch released from an interlock still needs
                        // its following slot squashed when there is no
                        // delay slot.
                        state_d = squash_next ? StSquash : StRun;
                    end
                end
                StSquash: begin
                    ex_d = '0;
                    // Stay here until the squashed instruction actually
                    // leaves ID; while it is interlocked it is still the
                    // slot instruction.
                    if (valid_i && !stall_req_o) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    ex_d    = '0;
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            ex_q    <= '0;
            state_q <= StRun;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
        end
    end

    assign ex_valid_o     = ex_q.vld;
    assign ex_we_o        = ex_q.we;
    assign ex_waddr_o     = ex_q.waddr;
    assign ex_reg0_data_o = ex_q.op0;
    assign ex_reg1_data_o = ex_q.op1;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: two builds (delay slot / no zero reg, and squash / zero reg)
// driven by the same stimulus and compared every cycle against a behavioural model.
// Directed literal checks pin the model; a randomized phase follows.
module tb_id_operand_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NF = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           valid, re0, re1, we, stall, flush;
    logic [DW-1:0]  pc, rd0, rd1, imm;
    logic [AW-1:0]  a0, a1, waddr;
    logic [1:0]     br;
    logic [NF-1:0]  fwe, fload;
    logic [NF*AW-1:0] fwaddr;
    logic [NF*DW-1:0] fwdata;

    logic [1:0]          sreq, bflag, exv, exwe;
    logic [1:0][DW-1:0]  baddr, exd0, exd1;
    logic [1:0][AW-1:0]  exwa;

    id_operand_stage #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .ZERO_REG(0), .DELAY_SLOT(1)
    ) u0 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc),
        .reg0_addr_i(a0), .reg1_addr_i(a1), .reg0_re_i(re0), .reg1_re_i(re1),
        .reg0_data_i(rd0), .reg1_data_i(rd1), .imm_i(imm), .br_type_i(br),
        .we_i(we), .waddr_i(waddr), .fwd_we_i(fwe), .fwd_load_i(fload),
        .fwd_waddr_i(fwaddr), .fwd_wdata_i(fwdata), .stall_i(stall), .flush_i(flush),
        .stall_req_o(sreq[0]), .branch_flag_o(bflag[0]), .branch_addr_o(baddr[0]),
        .ex_valid_o(exv[0]), .ex_reg0_data_o(exd0[0]), .ex_reg1_data_o(exd1[0]),
        .ex_we_o(exwe[0]), .ex_waddr_o(exwa[0])
    );

    id_operand_stage #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .ZERO_REG(1), .DELAY_SLOT(0)
    ) u1 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc),
        .reg0_addr_i(a0), .reg1_addr_i(a1), .reg0_re_i(re0), .reg1_re_i(re1),
        .reg0_data_i(rd0), .reg1_data_i(rd1), .imm_i(imm), .br_type_i(br),
        .we_i(we), .waddr_i(waddr), .fwd_we_i(fwe), .fwd_load_i(fload),
        .fwd_waddr_i(fwaddr), .fwd_wdata_i(fwdata), .stall_i(stall), .flush_i(flush),
        .stall_req_o(sreq[1]), .branch_flag_o(bflag[1]), .branch_addr_o(baddr[1]),
        .ex_valid_o(exv[1]), .ex_reg0_data_o(exd0[1]), .ex_reg1_data_o(exd1[1]),
        .ex_we_o(exwe[1]), .ex_waddr_o(exwa[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Instance 0: DELAY_SLOT=1, ZERO_REG=0.
    //                    Instance 1: DELAY_SLOT=0, ZERO_REG=1.
    // The EX register is modelled as plain values plus one flag saying
    // "the next instruction leaving ID must be discarded".
    // ------------------------------------------------------------------
    logic          m_v [2];
    logic          m_we[2];
    logic          m_sq[2];
    logic [AW-1:0] m_wa[2];
    logic [DW-1:0] m_d0[2];
    logic [DW-1:0] m_d1[2];

    task automatic resolve(input logic [AW-1:0] a, input logic re, input logic [DW-1:0] rf,
                           input bit zr, output logic [DW-1:0] d, output logic ld);
        bit found;
        found = 1'b0;
        d  = rf;
        ld = 1'b0;
        if (!re || (zr && a == '0)) begin
            d = '0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (!found && fwe[i] && fwaddr[i*AW +: AW] == a) begin
                    found = 1'b1;
                    d  = fwdata[i*DW +: DW];
                    ld = fload[i];
                end
            end
        end
    endtask

    task automatic model_comb(input int k, output logic st, output logic tk,
                              output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        logic l0, l1;
        bit   cond;
        resolve(a0, re0, rd0, (k == 1), d0, l0);
        resolve(a1, re1, rd1, (k == 1), d1, l1);
        st = valid & (l0 | l1);
        case (br)
            2'b01:   cond = 1'b1;
            2'b10:   cond = (d0 == '0);
            2'b11:   cond = (d0 != '0);
            default: cond = 1'b0;
        endcase
        tk = valid & ~st & ~m_sq[k] & cond;
    endtask

    always @(posedge clk or negedge rst) begin : model_seq
        logic st, tk;
        logic [DW-1:0] d0, d1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] <= 1'b0; m_we[k] <= 1'b0; m_sq[k] <= 1'b0;
                m_wa[k] <= '0;  m_d0[k] <= '0;   m_d1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                model_comb(k, st, tk, d0, d1);
                if (flush) begin
                    m_v[k] <= 1'b0; m_we[k] <= 1'b0; m_sq[k] <= 1'b0;
                    m_wa[k] <= '0;  m_d0[k] <= '0;   m_d1[k] <= '0;
                end else if (!stall) begin
                    if (st || m_sq[k]) begin
                        m_v[k] <= 1'b0; m_we[k] <= 1'b0;
                        m_wa[k] <= '0;  m_d0[k] <= '0; m_d1[k] <= '0;
                        if (!st && valid) m_sq[k] <= 1'b0;
                    end else begin
                        m_v[k]  <= valid;
                        m_we[k] <= we & valid;
                        m_wa[k] <= waddr;
                        m_d0[k] <= d0;
                        m_d1[k] <= d1;
                        if (tk && k == 1) m_sq[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, both builds.
    always @(negedge clk) begin : compare
        logic st, tk;
        logic [DW-1:0] d0, d1, tgt;
        for (int k = 0; k < 2; k++) begin
            model_comb(k, st, tk, d0, d1);
            tgt = pc + 16'd1 + imm;
            check($sformatf("u%0d.stall_req", k),   32'(sreq[k]),  32'(st));
            check($sformatf("u%0d.branch_flag", k), 32'(bflag[k]), 32'(tk));
            check($sformatf("u%0d.branch_addr", k), 32'(baddr[k]), 32'(tgt));
            check($sformatf("u%0d.ex_valid", k),    32'(exv[k]),   32'(m_v[k]));
            check($sformatf("u%0d.ex_we", k),       32'(exwe[k]),  32'(m_we[k]));
            check($sformatf("u%0d.ex_waddr", k),    32'(exwa[k]),  32'(m_wa[k]));
            check($sformatf("u%0d.ex_reg0", k),     32'(exd0[k]),  32'(m_d0[k]));
            check($sformatf("u%0d.ex_reg1", k),     32'(exd1[k]),  32'(m_d1[k]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        valid = 0; pc = '0; a0 = '0; a1 = '0; re0 = 0; re1 = 0; rd0 = '0; rd1 = '0;
        imm = '0; br = 2'b00; we = 0; waddr = '0; fwe = '0; fload = '0;
        fwaddr = '0; fwdata = '0; stall = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        // Reset with busy inputs
        valid = 1; a0 = 4'd3; re0 = 1; rd0 = 16'h1111; rd1 = 16'h2222; we = 1; waddr = 4'd7;
        step(); step();
        check("reset.ex_valid", 32'(exv[0]),  32'd0);
        check("reset.ex_we",    32'(exwe[0]), 32'd0);
        check("reset.ex_reg0",  32'(exd0[0]), 32'd0);
        check("reset.ex_waddr", 32'(exwa[0]), 32'd0);

        // First instruction after reset
        rst = 1'b1;
        idle(); valid = 1; a0 = 4'd3; re0 = 1; rd0 = 16'h0011;
        step();
        check("first.ex_reg0",  32'(exd0[0]), 32'h0011);
        check("first.ex_valid", 32'(exv[0]),  32'd1);

        // Forwarding priority
        fwe = 2'b11; fwaddr = {4'd3, 4'd3}; fwdata = {16'h00BB, 16'h00AA};
        step();
        check("prio.ch0", 32'(exd0[0]), 32'h00AA);
        fwe = 2'b10;
        step();
        check("prio.ch1", 32'(exd0[0]), 32'h00BB);

        // Load-use interlock, then release by a non-load in ch1
        idle(); valid = 1; a1 = 4'd2; re1 = 1; rd1 = 16'hDEAD; we = 1; waddr = 4'd4;
        fwe = 2'b01; fload = 2'b01; fwaddr = {4'd0, 4'd2};
        #1 check("load.stall_req", 32'(sreq[0]), 32'd1);
        check("load.no_branch", 32'(bflag[0]), 32'd0);
        step();
        check("load.bubble_v",  32'(exv[0]),  32'd0);
        check("load.bubble_we", 32'(exwe[0]), 32'd0);
        fwe = 2'b10; fload = 2'b00; fwaddr = {4'd2, 4'd0}; fwdata = {16'h1234, 16'h0000};
        #1 check("load.clear", 32'(sreq[0]), 32'd0);
        step();
        check("load.ex_reg1", 32'(exd1[0]), 32'h1234);
        check("load.ex_valid", 32'(exv[0]), 32'd1);

        // Branch taken on forwarded zero
        idle(); valid = 1; pc = 16'h0010; imm = 16'hFFFE; br = 2'b10; a0 = 4'd1; re0 = 1;
        rd0 = 16'h9999; fwe = 2'b01; fwaddr = {4'd0, 4'd1}; fwdata = {16'h0000, 16'h0000};
        #1 check("beqz.flag",  32'(bflag[0]), 32'd1);
        check("beqz.addr",  32'(baddr[0]), 32'h000F);
        check("beqz.flag1", 32'(bflag[1]), 32'd1);
        step();
        // Slot instruction: executes with delay slot, squashed without
        idle(); valid = 1; we = 1; waddr = 4'd6; a0 = 4'd5; re0 = 1; rd0 = 16'h0055;
        step();
        check("slot.ds1_valid", 32'(exv[0]),  32'd1);
        check("slot.ds1_reg0",  32'(exd0[0]), 32'h0055);
        check("slot.ds0_valid", 32'(exv[1]),  32'd0);
        check("slot.ds0_we",    32'(exwe[1]), 32'd0);
        // Branch not taken on forwarded 5
        idle(); valid = 1; pc = 16'h0010; imm = 16'hFFFE; br = 2'b10; a0 = 4'd1; re0 = 1;
        fwe = 2'b01; fwaddr = {4'd0, 4'd1}; fwdata = {16'h0000, 16'h0005};
        #1 check("beqz5.flag", 32'(bflag[0]), 32'd0);
        step();

        // Downstream stall holds EX for three cycles
        idle(); valid = 1; a0 = 4'd5; re0 = 1; rd0 = 16'h0042; we = 1; waddr = 4'd5;
        step();
        stall = 1; valid = 0; rd0 = 16'hFFFF; waddr = 4'd9;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall.reg0",  32'(exd0[0]), 32'h0042);
            check("stall.waddr", 32'(exwa[0]), 32'd5);
            check("stall.valid", 32'(exv[0]),  32'd1);
        end
        // Flush beats stall
        flush = 1; stall = 1;
        step();
        check("flush.valid0", 32'(exv[0]), 32'd0);
        check("flush.valid1", 32'(exv[1]), 32'd0);

        // Zero register: never forwarded or interlocked in the ZERO_REG build
        idle(); valid = 1; a0 = 4'd0; re0 = 1; rd0 = 16'h5555;
        fwe = 2'b01; fload = 2'b01; fwaddr = {4'd0, 4'd0}; fwdata = {16'h0000, 16'h7777};
        #1 check("zr.no_stall", 32'(sreq[1]), 32'd0);
        check("zr.stall_plain", 32'(sreq[0]), 32'd1);
        step();
        check("zr.reg0",  32'(exd0[1]), 32'h0000);
        check("zr.valid", 32'(exv[1]),  32'd1);

        // Reset in the middle of an interlock
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle(); valid = 1; a0 = 4'd2; re0 = 1; rd0 = 16'h0777;
        #1 check("rstmid.no_stall", 32'(sreq[0]), 32'd0);
        step();
        check("rstmid.valid", 32'(exv[0]),  32'd1);
        check("rstmid.reg0",  32'(exd0[0]), 32'h0777);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            valid  = ($urandom_range(0, 3) != 0);
            pc     = 16'($urandom);
            a0     = 4'($urandom_range(0, 3));
            a1     = 4'($urandom_range(0, 3));
            re0    = 1'($urandom_range(0, 1));
            re1    = 1'($urandom_range(0, 1));
            rd0    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rd1    = 16'($urandom);
            imm    = 16'($urandom);
            br     = 2'($urandom_range(0, 3));
            we     = 1'($urandom_range(0, 1));
            waddr  = 4'($urandom);
            fwe    = 2'($urandom_range(0, 3));
            fload  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            fwaddr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            fwdata = {($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                      ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom)};
            stall  = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 24) == 0);
            rst    = ($urandom_range(0, 199) != 0);
            step();
        end

        rst = 1'b1;
        idle();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
